// File: rtl/music_sequencer_if.sv
// Control and sound-mux signals between a game-level controller and the music sequencer.
interface music_sequencer_if;
  logic       startSong;
  logic       stopSong;
  logic       loopEnable;
  logic [3:0] musicNote;
  logic       musicPlayRequest;
  logic       songDone;
  logic       busy;

  modport master (
    output startSong, stopSong, loopEnable,
    input  musicNote, musicPlayRequest, songDone, busy
  );

  modport slave (
    input  startSong, stopSong, loopEnable,
    output musicNote, musicPlayRequest, songDone, busy
  );
endinterface

// File: rtl/music_sequencer.sv
// Background-music source: walks a {note, duration} table on a fixed tick base,
// with optional silent gaps, looping, stop/restart and an end-of-song pulse.
module music_sequencer #(
  parameter int unsigned TICK_CYCLES = 3_150_000,
  parameter int unsigned GAP_TICKS   = 1,
  parameter int unsigned SONG_LEN    = 16,
  parameter logic [SONG_LEN*8-1:0] SONG_ROM =
    (SONG_LEN*8)'(128'h00_F1_84_62_52_32_F1_14_52_32_12_F1_54_34_14_12)
) (
  input logic               clk,
  input logic               resetN,
  music_sequencer_if.slave  bus
);

  localparam int unsigned IW        = $clog2(SONG_LEN + 1);
  localparam int unsigned TW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned GW        = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;
  localparam int unsigned ROM_DEPTH = 2 ** IW;
  localparam logic [3:0]  REST_NOTE = 4'hF;
  // Zero padding past SONG_LEN reads as end-of-song markers, so lookups never go out of range.
  localparam logic [ROM_DEPTH*8-1:0] ROM_PAD = (ROM_DEPTH*8)'(SONG_ROM);

  typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [3:0]      dur_q, dur_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [3:0]      note_q, note_d;
  logic            req_q, req_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  logic [7:0]      rom_c [ROM_DEPTH];
  logic            tick_c;
  logic            do_load_c;
  logic [IW-1:0]   load_idx_c;
  logic [7:0]      entry_c;

  always_comb begin
    for (int i = 0; i < ROM_DEPTH; i++) rom_c[i] = ROM_PAD[i*8 +: 8];
  end

  assign tick_c = (state_q != IDLE) && (tick_q == TW'(TICK_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dur_d      = dur_q;
    gap_d      = gap_q;
    note_d     = note_q;
    req_d      = req_q;
    done_d     = 1'b0;
    tick_d     = (state_q == IDLE || tick_c) ? '0 : tick_q + TW'(1);
    do_load_c  = 1'b0;
    load_idx_c = '0;
    entry_c    = 8'h00;

    if (bus.stopSong) begin
      state_d = IDLE;
      idx_d   = '0;
      dur_d   = '0;
      gap_d   = '0;
      tick_d  = '0;
      note_d  = '0;
      req_d   = 1'b0;
    end else if (bus.startSong) begin
      do_load_c  = 1'b1;
      load_idx_c = '0;
    end else begin
      unique case (state_q)
        NOTE: if (tick_c) begin
          if (dur_q == 4'd1) begin
            if (GAP_TICKS > 0) begin
              state_d = GAP;
              gap_d   = GW'(GAP_TICKS);
              note_d  = '0;
              req_d   = 1'b0;
            end else begin
              do_load_c  = 1'b1;
              load_idx_c = idx_q + IW'(1);
            end
          end else begin
            dur_d = dur_q - 4'd1;
          end
        end
        GAP: if (tick_c) begin
          if (gap_q <= GW'(1)) begin
            do_load_c  = 1'b1;
            load_idx_c = idx_q + IW'(1);
          end else begin
            gap_d = gap_q - GW'(1);
          end
        end
        default: ;
      endcase
    end

    // Entry load, folding in end-of-song (table end or zero duration) and looping.
    if (do_load_c) begin
      entry_c = rom_c[load_idx_c];
      if (load_idx_c == IW'(SONG_LEN) || entry_c[3:0] == 4'd0) begin
        if (bus.loopEnable) begin
          load_idx_c = '0;
          entry_c    = rom_c[0];
        end else begin
          done_d = 1'b1;
        end
      end
      if (done_d || entry_c[3:0] == 4'd0) begin
        state_d = IDLE;
        idx_d   = '0;
        dur_d   = '0;
        gap_d   = '0;
        tick_d  = '0;
        note_d  = '0;
        req_d   = 1'b0;
      end else begin
        state_d = NOTE;
        idx_d   = load_idx_c;
        dur_d   = entry_c[3:0];
        gap_d   = '0;
        tick_d  = '0;
        note_d  = (entry_c[7:4] == REST_NOTE) ? 4'h0 : entry_c[7:4];
        req_d   = (entry_c[7:4] != REST_NOTE);
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tick_q  <= '0;
      dur_q   <= '0;
      gap_q   <= '0;
      note_q  <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tick_q  <= tick_d;
      dur_q   <= dur_d;
      gap_q   <= gap_d;
      note_q  <= note_d;
      req_q   <= req_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.musicNote        = note_q;
  assign bus.musicPlayRequest = req_q;
  assign bus.songDone         = done_q;
  assign bus.busy             = busy_q;

endmodule

// File: tb/tb_music_sequencer.sv
// Directed bench for music_sequencer: a four-entry song, plus a second instance
// whose first entry is an end-of-song marker.
module tb_music_sequencer;

  logic clk = 1'b0;
  logic resetN;

  music_sequencer_if if_a ();
  music_sequencer_if if_b ();

  music_sequencer #(
    .TICK_CYCLES (4),
    .GAP_TICKS   (1),
    .SONG_LEN    (4),
    .SONG_ROM    (32'h00_71_F1_32)
  ) u_dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (if_a)
  );

  music_sequencer #(
    .TICK_CYCLES (4),
    .GAP_TICKS   (1),
    .SONG_LEN    (4),
    .SONG_ROM    (32'h00_71_F1_50)
  ) u_dut_empty (
    .clk    (clk),
    .resetN (resetN),
    .bus    (if_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [6:0] obs(bit sel);
    if (sel) return {if_b.musicNote, if_b.musicPlayRequest, if_b.songDone, if_b.busy};
    return {if_a.musicNote, if_a.musicPlayRequest, if_a.songDone, if_a.busy};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compares {note, req, done, busy}.
  task automatic chk(string tag, logic [6:0] got, logic [6:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run(bit sel, string tag, logic [3:0] n, logic r, logic d, logic b, int cycles);
    for (int c = 0; c < cycles; c++) begin
      chk($sformatf("%s[%0d]", tag, c), obs(sel), {n, r, d, b});
      step();
    end
  endtask

  task automatic pulse_start_a();
    if_a.startSong = 1'b1;
    step();
    if_a.startSong = 1'b0;
  endtask

  task automatic pulse_stop_a();
    if_a.stopSong = 1'b1;
    step();
    if_a.stopSong = 1'b0;
  endtask

  initial begin
    resetN          = 1'b0;
    if_a.startSong  = 1'b0;
    if_a.stopSong   = 1'b0;
    if_a.loopEnable = 1'b0;
    if_b.startSong  = 1'b0;
    if_b.stopSong   = 1'b0;
    if_b.loopEnable = 1'b0;
    #12;
    chk("reset_a", obs(0), 7'h00);
    chk("reset_b", obs(1), 7'h00);
    step();
    resetN = 1'b1;
    step();

    // Full song, no loop
    pulse_start_a();
    run(0, "t2_note3", 4'h3, 1, 0, 1, 8);
    run(0, "t2_gap0",  4'h0, 0, 0, 1, 4);
    run(0, "t2_rest",  4'h0, 0, 0, 1, 4);
    run(0, "t2_gap1",  4'h0, 0, 0, 1, 4);
    run(0, "t2_note7", 4'h7, 1, 0, 1, 4);
    run(0, "t2_gap2",  4'h0, 0, 0, 1, 4);
    run(0, "t2_done",  4'h0, 0, 1, 0, 1);
    run(0, "t2_idle",  4'h0, 0, 0, 0, 3);

    // Looping: wraps to note 3 without songDone
    if_a.loopEnable = 1'b1;
    pulse_start_a();
    run(0, "t3_note3", 4'h3, 1, 0, 1, 8);
    run(0, "t3_gap0",  4'h0, 0, 0, 1, 4);
    run(0, "t3_rest",  4'h0, 0, 0, 1, 4);
    run(0, "t3_gap1",  4'h0, 0, 0, 1, 4);
    run(0, "t3_note7", 4'h7, 1, 0, 1, 4);
    run(0, "t3_gap2",  4'h0, 0, 0, 1, 4);
    run(0, "t3_wrap",  4'h3, 1, 0, 1, 8);
    run(0, "t3_gap3",  4'h0, 0, 0, 1, 2);
    pulse_stop_a();
    run(0, "t3_stop",  4'h0, 0, 0, 0, 2);
    if_a.loopEnable = 1'b0;

    // Stop during note 7, then simultaneous start+stop
    pulse_start_a();
    run(0, "t4_note3", 4'h3, 1, 0, 1, 8);
    run(0, "t4_gap0",  4'h0, 0, 0, 1, 4);
    run(0, "t4_rest",  4'h0, 0, 0, 1, 4);
    run(0, "t4_gap1",  4'h0, 0, 0, 1, 4);
    run(0, "t4_note7", 4'h7, 1, 0, 1, 2);
    pulse_stop_a();
    run(0, "t4_stop",  4'h0, 0, 0, 0, 3);
    if_a.startSong = 1'b1;
    if_a.stopSong  = 1'b1;
    step();
    if_a.startSong = 1'b0;
    if_a.stopSong  = 1'b0;
    run(0, "t4_both",  4'h0, 0, 0, 0, 3);

    // Restart during the rest: full-length note 3 again
    pulse_start_a();
    run(0, "t5_note3", 4'h3, 1, 0, 1, 8);
    run(0, "t5_gap0",  4'h0, 0, 0, 1, 4);
    run(0, "t5_rest",  4'h0, 0, 0, 1, 2);
    pulse_start_a();
    run(0, "t5_again", 4'h3, 1, 0, 1, 8);
    run(0, "t5_gap",   4'h0, 0, 0, 1, 1);
    pulse_stop_a();
    run(0, "t5_stop",  4'h0, 0, 0, 0, 1);

    // Asynchronous reset mid-note
    pulse_start_a();
    run(0, "t1_note3", 4'h3, 1, 0, 1, 3);
    #2;
    resetN = 1'b0;
    #1;
    chk("t1_async", obs(0), 7'h00);
    step();
    resetN = 1'b1;
    step();
    run(0, "t1_after", 4'h0, 0, 0, 0, 2);

    // Entry 0 is an end-of-song marker
    if_b.startSong = 1'b1;
    step();
    if_b.startSong = 1'b0;
    run(1, "t6_done",  4'h0, 0, 1, 0, 1);
    run(1, "t6_idle",  4'h0, 0, 0, 0, 2);
    if_b.loopEnable = 1'b1;
    if_b.startSong  = 1'b1;
    step();
    if_b.startSong  = 1'b0;
    run(1, "t6_spin",  4'h0, 0, 0, 0, 3);
    if_b.loopEnable = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
